// File: rtl/csr_bank.sv
// ============================================================================
// Module   : csr_bank
// Purpose  : Control/status register bank for the memory checker. It holds
//            PARAM_CNT read/write test-parameter words and RES_CNT read-only
//            captured-result words behind an Avalon-MM slave. A two-state test
//            controller (IDLE/RUN) issues start/abort pulses, reports busy,
//            keeps a sticky done flag and drives a level interrupt.
// Options  : CSR_TIMEOUT_EN - when defined, adds a RUN-state watchdog that
//            aborts the test after TIMEOUT_CYCLES cycles and sets the
//            STATUS timeout flag. When undefined, STATUS bit2 reads 0.
// Ports    : clk_sys_i, rst_n_i          - clock, async active-low reset
//            read_i/write_i/address_i/
//            writedata_i/byteenable_i/
//            readdata_o                  - Avalon-MM slave, 1-cycle read latency
//            result_valid_i, result_i    - result capture from the checker
//            start_test_o, abort_test_o  - one-cycle command pulses
//            test_param_reg_o            - flattened parameter registers
//            busy_o, irq_o               - RUN indicator, level interrupt
// Map      : 0 CTRL, 1 STATUS, 2.. params, 2+PARAM_CNT.. results, else 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_bank #(
  parameter int PARAM_CNT      = 3,
  parameter int RES_CNT        = 11,
  parameter int AMM_ADDR_W     = 5,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                    clk_sys_i,
  input  logic                    rst_n_i,
  input  logic                    read_i,
  input  logic                    write_i,
  input  logic [AMM_ADDR_W-1:0]   address_i,
  input  logic [31:0]             writedata_i,
  input  logic [3:0]              byteenable_i,
  output logic [31:0]             readdata_o,
  input  logic                    result_valid_i,
  input  logic [RES_CNT*32-1:0]   result_i,
  output logic                    start_test_o,
  output logic                    abort_test_o,
  output logic [PARAM_CNT*32-1:0] test_param_reg_o,
  output logic                    busy_o,
  output logic                    irq_o
);

  localparam int RES_BASE = 2 + PARAM_CNT;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e      state_q;
  logic        irq_en_q;
  logic        done_q;
  logic        timeout_q;
  logic        start_rej_q;
  logic        start_q;
  logic        abort_q;
  logic        irq_q;
  logic [31:0] param_q  [PARAM_CNT];
  logic [31:0] result_q [RES_CNT];
  logic [31:0] readdata_q;
  logic [31:0] readdata_d;

  // CTRL commands only take effect when the low byte lane is enabled.
  logic ctrl_wr;
  logic status_rd;
  logic start_cmd;
  logic abort_cmd;
  logic wd_expire;

  assign ctrl_wr   = write_i & (address_i == AMM_ADDR_W'(0)) & byteenable_i[0];
  assign status_rd = read_i & (address_i == AMM_ADDR_W'(1));
  assign start_cmd = ctrl_wr & writedata_i[0];
  assign abort_cmd = ctrl_wr & writedata_i[1];

`ifdef CSR_TIMEOUT_EN
  // Counter sits at zero in IDLE, so it is already cleared on RUN entry.
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;

  assign wd_expire = (state_q == ST_RUN) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wd_q <= '0;
    end else if (state_q == ST_RUN) begin
      wd_q <= wd_q + WD_W'(1);
    end else begin
      wd_q <= '0;
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  // Read mux: unmapped addresses fall through to zero.
  always_comb begin
    readdata_d = '0;
    if (address_i == AMM_ADDR_W'(0)) begin
      readdata_d = {29'd0, irq_en_q, 2'b00};
    end else if (address_i == AMM_ADDR_W'(1)) begin
      readdata_d = {28'd0, start_rej_q, timeout_q, (state_q == ST_RUN), done_q};
    end
    for (int p = 0; p < PARAM_CNT; p++) begin
      if (address_i == AMM_ADDR_W'(2 + p)) readdata_d = param_q[p];
    end
    for (int r = 0; r < RES_CNT; r++) begin
      if (address_i == AMM_ADDR_W'(RES_BASE + r)) readdata_d = result_q[r];
    end
  end

  // Test controller and register storage. Flag-set events are written after
  // the STATUS read-clear so that a coincident set wins.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      start_rej_q <= 1'b0;
      start_q     <= 1'b0;
      abort_q     <= 1'b0;
      irq_q       <= 1'b0;
      readdata_q  <= '0;
      for (int p = 0; p < PARAM_CNT; p++) param_q[p]  <= '0;
      for (int r = 0; r < RES_CNT; r++)   result_q[r] <= '0;
    end else begin
      start_q <= 1'b0;
      abort_q <= 1'b0;
      irq_q   <= irq_en_q & (done_q | timeout_q);

      if (read_i) readdata_q <= readdata_d;

      if (ctrl_wr) irq_en_q <= writedata_i[2];

      if (status_rd) begin
        done_q      <= 1'b0;
        timeout_q   <= 1'b0;
        start_rej_q <= 1'b0;
      end

      // Parameters are frozen while a test runs.
      if (write_i && (state_q == ST_IDLE)) begin
        for (int p = 0; p < PARAM_CNT; p++) begin
          if (address_i == AMM_ADDR_W'(2 + p)) begin
            for (int b = 0; b < 4; b++) begin
              if (byteenable_i[b]) param_q[p][8*b +: 8] <= writedata_i[8*b +: 8];
            end
          end
        end
      end

      case (state_q)
        ST_IDLE: begin
          // A simultaneous abort bit is meaningless here; start alone acts.
          if (start_cmd) begin
            state_q   <= ST_RUN;
            start_q   <= 1'b1;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (start_cmd) start_rej_q <= 1'b1;
          // Result completion takes precedence over abort and watchdog.
          if (result_valid_i) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
            for (int r = 0; r < RES_CNT; r++) result_q[r] <= result_i[32*r +: 32];
          end else if (abort_cmd || wd_expire) begin
            state_q <= ST_IDLE;
            abort_q <= 1'b1;
            if (wd_expire) timeout_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar p = 0; p < PARAM_CNT; p++) begin : g_param_out
    assign test_param_reg_o[32*p +: 32] = param_q[p];
  end

  assign readdata_o   = readdata_q;
  assign start_test_o = start_q;
  assign abort_test_o = abort_q;
  assign busy_o       = (state_q == ST_RUN);
  assign irq_o        = irq_q;

endmodule

`default_nettype wire

// File: doc/csr_bank.md
# csr_bank

Parametrised single-clock control/status register bank between the system Avalon-MM slave and the memory checker core. Holds a configurable number of test-parameter registers and captured-result registers, and runs a small test-control state machine: start, abort, busy, sticky done with interrupt, and an optional watchdog. Supersedes the fixed-map CSR block for designs where checker and bus share `clk_sys_i`.

## Interface

- `PARAM_CNT`, 3, number of RW test-parameter registers (1..8)
- `RES_CNT`, 11, number of RO result registers (1..16)
- `AMM_ADDR_W`, 5, Avalon address width; 2**AMM_ADDR_W >= 2+PARAM_CNT+RES_CNT
- `TIMEOUT_CYCLES`, 1048576, watchdog limit in clk_sys_i cycles (used only with `CSR_TIMEOUT_EN`)

Ports:
- `clk_sys_i`  in  1  sole clock
- `rst_n_i`  in  1  asynchronous, active-low reset
- `read_i`  in  1  Avalon read strobe
- `write_i`  in  1  Avalon write strobe
- `address_i`  in  AMM_ADDR_W  word address
- `writedata_i`  in  32  write data
- `byteenable_i`  in  4  byte lanes for writes
- `readdata_o`  out  32  read data, 1-cycle latency
- `result_valid_i`  in  1  one-cycle strobe from checker: results final
- `result_i`  in  RES_CNT*32  flattened result words, word k at [32k+31:32k]
- `start_test_o`  out  1  one-cycle start pulse
- `abort_test_o`  out  1  one-cycle abort pulse
- `test_param_reg_o`  out  PARAM_CNT*32  flattened parameter registers
- `busy_o`  out  1  high while state is RUN
- `irq_o`  out  1  level interrupt

## Operation

- Map: 0 CTRL, 1 STATUS, 2..1+PARAM_CNT params, 2+PARAM_CNT..1+PARAM_CNT+RES_CNT results; other addresses read 0, writes ignored.
- CTRL write: bit0 start, bit1 abort (self-clearing commands, read 0), bit2 irq_en (stored, read back). Honours byteenable_i[0].
- STATUS (RO): bit0 done, bit1 busy, bit2 timeout, bit3 start_rejected. Bits 0, 2, 3 sticky, cleared by a read of address 1.
- Param writes apply per byte lane, only in IDLE; writes during RUN are dropped.
- States: IDLE, RUN.
  - IDLE + CTRL write with bit0=1 -> RUN; `start_test_o` pulses the next cycle; done and timeout cleared at the same edge.
  - RUN + `result_valid_i` -> IDLE; all RES_CNT words captured; done set.
  - RUN + CTRL write with bit1=1 -> IDLE; `abort_test_o` pulses; done not set; results unchanged.
  - RUN + watchdog expiry -> IDLE; `abort_test_o` pulses; timeout set.
  - RUN + CTRL write with bit0=1 -> ignored; start_rejected set.
- `result_valid_i` in IDLE ignored. Abort in IDLE ignored.
- `irq_o` = irq_en & (done | timeout), registered.

## Timing

- Reset: all outputs 0, state IDLE, params, results, CTRL, STATUS flags 0, watchdog 0.
- `readdata_o` updates on the edge after `read_i`; holds otherwise.
- STATUS read returns pre-clear value; a flag set event in the same cycle as its clearing read wins (flag stays set).
- Start write in cycle N: `busy_o` and `start_test_o` high from edge N+1; `start_test_o` low at N+2.
- `result_valid_i` in N: results readable and done set from N+1; `busy_o` low from N+1; `irq_o` high from N+2.
- Same-cycle `result_valid_i` and abort write in RUN: result wins (done, no abort pulse).
- Same-cycle watchdog expiry and `result_valid_i`: result wins.
- CTRL write with bits0 and 1 both set in IDLE: start only.
- Read and write same cycle: both honoured; read returns pre-write value.
- `rst_n_i` mid-RUN: immediate return to IDLE, no pulses.

## Configuration

- `CSR_TIMEOUT_EN` defined: cycle counter runs in RUN, cleared on entry; at count TIMEOUT_CYCLES-1 expires as above.
- Undefined: no counter logic; RUN exits only via result or abort; STATUS bit2 reads 0.

## Test plan

- Reset, read all addresses -> every read 0, all outputs 0.
- Write param0=0xA5A5A5A5, byteenable=4'b0010 write 0x0000FF00 -> param0 reads 0xA5A5FFA5 and `test_param_reg_o[31:0]` matches.
- CTRL=0x5, then `result_valid_i` with word0=0x12345678 -> one `start_test_o` pulse, busy 1, then result0 reads 0x12345678, STATUS 0x1, `irq_o` 1; second STATUS read 0x0, `irq_o` 0.
- In RUN write CTRL=0x1 and param0=0 -> STATUS bit3 set, param0 unchanged; CTRL=0x2 -> one `abort_test_o` pulse, STATUS 0x8 then 0x0.
- `result_valid_i` coinciding with STATUS read -> read returns 0x2, done remains set afterward.
- With `CSR_TIMEOUT_EN`, TIMEOUT_CYCLES=100: start, no result -> `abort_test_o` 100 cycles after start, STATUS 0x4.
